fp_exp_align: RTL and testbench

- Pipelined floating-point operand alignment unit that sits in front of the FP adder/subtractor mantissa datapath.
- Computes the exponent difference magnitude and the larger exponent, and orders the operands so the larger magnitude comes first.
- Right-shifts the smaller mantissa with guard, round and sticky generation.
- Two register stages with valid/ready handshake on both sides; full backpressure support.

---
 rtl/fp_exp_align_if.sv | 34 +++
 rtl/fp_exp_align.sv | 106 ++++++++++
 tb/tb_fp_exp_align.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_exp_align_if.sv
// Operand/result handshake bundle for the FP exponent alignment unit.
// The master drives operands and out_ready; the slave (the aligner) drives results and in_ready.
interface fp_exp_align_if #(
  parameter int EXP_MAX_W = 16,
  parameter int MAN_W     = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic [EXP_MAX_W-1:0] e_a;
  logic [EXP_MAX_W-1:0] e_b;
  logic [MAN_W-1:0]     man_a;
  logic [MAN_W-1:0]     man_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [EXP_MAX_W-1:0] out_e_larger;
  logic [EXP_MAX_W:0]   out_diff;
  logic                 out_swap;
  logic [MAN_W-1:0]     out_man_large;
  logic [MAN_W+1:0]     out_man_small;
  logic                 out_sticky;
  logic                 out_far;

  modport master (
    output in_valid, e_a, e_b, man_a, man_b, out_ready,
    input  in_ready, out_valid, out_e_larger, out_diff, out_swap,
           out_man_large, out_man_small, out_sticky, out_far
  );

  modport slave (
    input  in_valid, e_a, e_b, man_a, man_b, out_ready,
    output in_ready, out_valid, out_e_larger, out_diff, out_swap,
           out_man_large, out_man_small, out_sticky, out_far
  );
endinterface

// File: rtl/fp_exp_align.sv
// Two-stage FP operand aligner: stage 1 orders operands by magnitude and takes |e_a-e_b|,
// stage 2 right-shifts the smaller mantissa with guard/round/sticky.
module fp_exp_align #(
  parameter int EXP_MAX_W = 16,
  parameter int MAN_W     = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_exp_align_if.slave bus
);
  localparam int STAGES = 2;
  localparam int DW     = EXP_MAX_W + 1;
  localparam int SW     = MAN_W + 2;
  localparam int SHW    = $clog2(SW + 1);
  localparam logic [DW-1:0]  SW_D   = DW'(SW);
  localparam logic [DW-1:0]  SWM1_D = DW'(SW - 1);
  localparam logic [SHW-1:0] SW_S   = SHW'(SW);

  typedef struct packed {
    logic [EXP_MAX_W-1:0] e_larger;
    logic [DW-1:0]        diff;
    logic                 swap;
    logic [MAN_W-1:0]     man_large;
    logic [MAN_W-1:0]     man_small;
  } s1_t;

  typedef struct packed {
    logic [EXP_MAX_W-1:0] e_larger;
    logic [DW-1:0]        diff;
    logic                 swap;
    logic [MAN_W-1:0]     man_large;
    logic [SW-1:0]        man_small;
    logic                 sticky;
    logic                 far;
  } s2_t;

  logic [STAGES:1] vld_pipe_q;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic            s1_en, s2_en;

  assign s2_en       = !vld_pipe_q[2] | bus.out_ready;
  assign s1_en       = !vld_pipe_q[1] | s2_en;
  assign bus.in_ready = s1_en;

  // Sign-extend one bit so the difference of any two exponents is representable.
  logic signed [DW-1:0] ea_x, eb_x, diff_s, diff_n;
  logic                 swap;
  assign ea_x   = {bus.e_a[EXP_MAX_W-1], bus.e_a};
  assign eb_x   = {bus.e_b[EXP_MAX_W-1], bus.e_b};
  assign diff_s = ea_x - eb_x;
  assign diff_n = -diff_s;
  assign swap   = (eb_x > ea_x) | ((ea_x == eb_x) & (bus.man_b > bus.man_a));

  always_comb begin
    s1_d           = '0;
    s1_d.swap      = swap;
    s1_d.e_larger  = swap ? bus.e_b : bus.e_a;
    s1_d.diff      = diff_s[DW-1] ? diff_n : diff_s;
    s1_d.man_large = swap ? bus.man_b : bus.man_a;
    s1_d.man_small = swap ? bus.man_a : bus.man_b;
  end

  // Shift into a double-width window: upper half is the aligned value, lower half feeds sticky.
  logic [SHW-1:0]  sh;
  logic [2*SW-1:0] shifted;
  assign sh      = (s1_q.diff > SW_D) ? SW_S : s1_q.diff[SHW-1:0];
  assign shifted = {s1_q.man_small, 2'b00, {SW{1'b0}}} >> sh;

  always_comb begin
    s2_d           = '0;
    s2_d.e_larger  = s1_q.e_larger;
    s2_d.diff      = s1_q.diff;
    s2_d.swap      = s1_q.swap;
    s2_d.man_large = s1_q.man_large;
    s2_d.man_small = shifted[2*SW-1:SW];
    s2_d.sticky    = |shifted[SW-1:0];
    s2_d.far       = s1_q.diff > SWM1_D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      if (s1_en) begin
        vld_pipe_q[1] <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (s2_en) begin
        vld_pipe_q[2] <= vld_pipe_q[1];
        if (vld_pipe_q[1]) s2_q <= s2_d;
      end
    end
  end

  assign bus.out_valid     = vld_pipe_q[STAGES];
  assign bus.out_e_larger  = s2_q.e_larger;
  assign bus.out_diff      = s2_q.diff;
  assign bus.out_swap      = s2_q.swap;
  assign bus.out_man_large = s2_q.man_large;
  assign bus.out_man_small = s2_q.man_small;
  assign bus.out_sticky    = s2_q.sticky;
  assign bus.out_far       = s2_q.far;
endmodule

// File: tb/tb_fp_exp_align.sv
// Bench for fp_exp_align: directed spec cases plus random streams checked against an
// arithmetic reference model, with backpressure, stability and mid-flight reset checks.
module tb_fp_exp_align;
  localparam int EW = 16;
  localparam int MW = 24;

  typedef struct {
    logic [EW-1:0]   e_larger;
    logic [EW:0]     diff;
    logic            swap;
    logic [MW-1:0]   man_large;
    logic [MW+1:0]   man_small;
    logic            sticky;
    logic            far;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   npop   = 0;
  exp_t q[$];

  fp_exp_align_if #(.EXP_MAX_W(EW), .MAN_W(MW)) ifc ();
  fp_exp_align #(.EXP_MAX_W(EW), .MAN_W(MW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;

  task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the signed exponents and mantissa values.
  function automatic exp_t model(logic [EW-1:0] ea, logic [EW-1:0] eb,
                                 logic [MW-1:0] ma, logic [MW-1:0] mb);
    exp_t   r;
    int     sa, sb, d, ad;
    longint ms, x;
    sa = int'($signed(ea));
    sb = int'($signed(eb));
    d  = sa - sb;
    ad = (d < 0) ? -d : d;
    r.swap      = (sb > sa) || (sa == sb && mb > ma);
    r.e_larger  = r.swap ? eb : ea;
    r.diff      = (EW+1)'(ad);
    r.man_large = r.swap ? mb : ma;
    ms          = longint'(r.swap ? ma : mb);
    x           = ms * 4;
    if (ad > MW + 2) begin
      r.man_small = '0;
      r.sticky    = (ms != 0);
    end else begin
      r.man_small = (MW+2)'(x >> ad);
      r.sticky    = (x % (64'sd1 << ad)) != 0;
    end
    r.far = ad > MW + 1;
    return r;
  endfunction

  function automatic logic [127:0] out_vec();
    return {41'b0, ifc.out_valid, ifc.out_e_larger, ifc.out_diff, ifc.out_swap,
            ifc.out_man_large, ifc.out_man_small, ifc.out_sticky, ifc.out_far};
  endfunction

  task automatic check_out(input exp_t e, input string tag);
    chk(128'(ifc.out_e_larger),  128'(e.e_larger),  {tag, ".e_larger"});
    chk(128'(ifc.out_diff),      128'(e.diff),      {tag, ".diff"});
    chk(128'(ifc.out_swap),      128'(e.swap),      {tag, ".swap"});
    chk(128'(ifc.out_man_large), 128'(e.man_large), {tag, ".man_large"});
    chk(128'(ifc.out_man_small), 128'(e.man_small), {tag, ".man_small"});
    chk(128'(ifc.out_sticky),    128'(e.sticky),    {tag, ".sticky"});
    chk(128'(ifc.out_far),       128'(e.far),       {tag, ".far"});
  endtask

  // Output monitor: in-order scoreboard and hold-stability under backpressure.
  logic         hold = 1'b0;
  logic [127:0] prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) chk(out_vec(), prev, "stall_stable");
      if (ifc.out_valid && ifc.out_ready) begin
        if (q.size() == 0) begin
          errors++;
          $error("FAIL unexpected_result observed=valid expected=none");
        end else begin
          check_out(q.pop_front(), "sb");
          npop++;
        end
      end
      hold = ifc.out_valid && !ifc.out_ready;
      prev = out_vec();
    end
  end

  task automatic drive(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                       input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    ifc.in_valid = 1'b1;
    ifc.e_a = ea; ifc.e_b = eb; ifc.man_a = ma; ifc.man_b = mb;
  endtask

  task automatic rand_op(output logic [EW-1:0] ea, output logic [EW-1:0] eb,
                         output logic [MW-1:0] ma, output logic [MW-1:0] mb);
    ea = EW'($urandom_range(80)) - EW'(40);
    eb = ($urandom_range(3) == 0) ? ea : EW'($urandom_range(80)) - EW'(40);
    if ($urandom_range(7) == 0) begin ea = EW'($urandom); eb = EW'($urandom); end
    ma = MW'($urandom);
    mb = ($urandom_range(5) == 0) ? ma : MW'($urandom);
    if ($urandom_range(9) == 0) mb = '0;
  endtask

  // Present one op (called at posedge+1); returns at posedge+1 after the accepting edge.
  task automatic send(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                      input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    bit acc = 0;
    drive(ea, eb, ma, mb);
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (ifc.in_ready) begin q.push_back(model(ea, eb, ma, mb)); acc = 1; end
      @(posedge clk); #1;
    end
    if (!acc) begin errors++; $error("FAIL send_timeout observed=blocked expected=accept"); end
    ifc.in_valid = 1'b0;
  endtask

  // Back-to-back random ops; out_ready dropped for stall_len cycles from cycle stall_at.
  task automatic stream(input int n, input int stall_at, input int stall_len, output bit blocked);
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    int sent = 0;
    blocked = 0;
    rand_op(ea, eb, ma, mb);
    for (int c = 0; c < 200 && sent < n; c++) begin
      ifc.out_ready = !(c >= stall_at && c < stall_at + stall_len);
      drive(ea, eb, ma, mb);
      @(negedge clk);
      if (ifc.in_ready) begin
        q.push_back(model(ea, eb, ma, mb));
        sent++;
        rand_op(ea, eb, ma, mb);
      end else blocked = 1;
      @(posedge clk); #1;
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    chk(128'(sent), 128'(n), "stream_sent");
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk(128'(q.size()), 128'(0), tag);
  endtask

  // Directed op: out_valid must be low one cycle after acceptance and high the next.
  task automatic directed(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                          input logic [MW-1:0] ma, input logic [MW-1:0] mb, input string tag);
    send(ea, eb, ma, mb);
    chk(128'(ifc.out_valid), 128'(0), {tag, ".lat_early"});
    @(posedge clk); #1;
    chk(128'(ifc.out_valid), 128'(1), {tag, ".lat"});
  endtask

  initial begin
    bit blocked;
    int p0;
    rst_n = 1'b0;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    ifc.e_a = '0; ifc.e_b = '0; ifc.man_a = '0; ifc.man_b = '0;
    #1;
    chk(out_vec(), 128'(0), "reset_outputs");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk(128'(ifc.in_ready), 128'(1), "reset_in_ready");
    chk(out_vec(), 128'(0), "reset_released");

    directed(16'd5, 16'd2, 24'h800000, 24'hC00000, "basic");
    chk(128'(ifc.out_e_larger), 128'(5), "basic.e_larger");
    chk(128'(ifc.out_diff), 128'(3), "basic.diff");
    chk(128'(ifc.out_swap), 128'(0), "basic.swap");
    chk(128'(ifc.out_man_small), 128'(26'h0600000), "basic.man_small");
    chk(128'(ifc.out_sticky), 128'(0), "basic.sticky");
    chk(128'(ifc.out_far), 128'(0), "basic.far");

    directed(-16'sd3, 16'd4, 24'hFFFFFF, 24'h800000, "neg_exp");
    chk(128'(ifc.out_swap), 128'(1), "neg_exp.swap");
    chk(128'(ifc.out_e_larger), 128'(4), "neg_exp.e_larger");
    chk(128'(ifc.out_diff), 128'(7), "neg_exp.diff");
    chk(128'(ifc.out_man_large), 128'(24'h800000), "neg_exp.man_large");
    chk(128'(ifc.out_sticky), 128'(1), "neg_exp.sticky");

    directed(16'd10, 16'd10, 24'h900000, 24'hA00000, "eq_exp");
    chk(128'(ifc.out_swap), 128'(1), "eq_exp.swap");
    chk(128'(ifc.out_diff), 128'(0), "eq_exp.diff");
    chk(128'(ifc.out_man_small), 128'(26'h2400000), "eq_exp.man_small");
    chk(128'(ifc.out_sticky), 128'(0), "eq_exp.sticky");

    directed(16'd10, 16'd10, 24'hA00000, 24'hA00000, "eq_all");
    chk(128'(ifc.out_swap), 128'(0), "eq_all.swap");

    directed(16'd40, 16'd0, 24'h800000, 24'h000001, "far");
    chk(128'(ifc.out_diff), 128'(40), "far.diff");
    chk(128'(ifc.out_far), 128'(1), "far.far");
    chk(128'(ifc.out_man_small), 128'(0), "far.man_small");
    chk(128'(ifc.out_sticky), 128'(1), "far.sticky");

    directed(16'd26, 16'd0, 24'h800000, 24'h000001, "edge26");
    chk(128'(ifc.out_far), 128'(1), "edge26.far");
    chk(128'(ifc.out_sticky), 128'(1), "edge26.sticky");
    directed(16'd25, 16'd0, 24'h800000, 24'h800000, "edge25");
    chk(128'(ifc.out_far), 128'(0), "edge25.far");
    chk(128'(ifc.out_man_small), 128'(1), "edge25.man_small");

    directed(16'h7FFF, 16'h8000, 24'h123456, 24'h654321, "extreme");
    chk(128'(ifc.out_diff), 128'(17'hFFFF), "extreme.diff");
    chk(128'(ifc.out_e_larger), 128'(16'h7FFF), "extreme.e_larger");
    chk(128'(ifc.out_swap), 128'(0), "extreme.swap");

    directed(16'd3, 16'd8, 24'h000000, 24'h800000, "zero_man");
    chk(128'(ifc.out_sticky), 128'(0), "zero_man.sticky");
    drain("drain_directed");

    // Full throughput: 6 ops, one accepted and one produced per cycle.
    p0 = npop;
    stream(6, 1000, 0, blocked);
    chk(128'(blocked), 128'(0), "thru_no_block");
    chk(128'(npop - p0), 128'(4), "thru_pops_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk(128'(npop - p0), 128'(6), "thru_pops_all");
    drain("drain_thru");

    // Backpressure: 4-cycle stall mid-stream.
    p0 = npop;
    stream(6, 2, 4, blocked);
    chk(128'(blocked), 128'(1), "bp_in_ready_drop");
    drain("drain_bp");
    chk(128'(npop - p0), 128'(6), "bp_count");

    for (int r = 0; r < 8; r++) begin
      p0 = npop;
      stream(20, int'($urandom_range(15)), int'($urandom_range(5)), blocked);
      drain("drain_rand");
      chk(128'(npop - p0), 128'(20), "rand_count");
    end

    // Reset with two ops in flight.
    send(16'd7, 16'd1, 24'hABCDEF, 24'h123456);
    send(16'd2, 16'd9, 24'h111111, 24'h222222);
    rst_n = 1'b0;
    #1;
    chk(out_vec(), 128'(0), "mid_reset_outputs");
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk(128'(ifc.in_ready), 128'(1), "mid_reset_in_ready");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk(128'(ifc.out_valid), 128'(0), "no_stale_result");
    end
    directed(16'd5, 16'd2, 24'h800000, 24'hC00000, "post_reset");
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
